exec_stage_p: RTL
=================

# exec_stage_p

Parametrised execute stage for the pipelined RISC core, sitting between register-read and memory-access. Executes ADD/NAND/LHI-class operations with carry/zero-conditional variants, adds valid/ready handshaking with backpressure in both directions, and optionally adds an iterative multi-cycle multiply. Results and flags are held in an output register until memory-access accepts them. Flags commit only on that output handshake, so flushed instructions never corrupt C/Z.

## Interface
- DATA_W, 16, operand/result width; must be ≥ 9.
- RD_W, 3, destination register index width.
- TAG_W, 2, opaque side-band bits passed through unchanged.
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- flush  in  1  kill output register contents and any in-flight multiply.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_op  in  5  opcode.
- in_opa  in  DATA_W  operand A (also store data).
- in_opb  in  DATA_W  operand B; `in_opb[8:0]` is the LHI immediate.
- in_rd  in  RD_W  destination register.
- in_tag  in  TAG_W  side-band bits.
- out_valid  out  1  output register holds a result.
- out_ready  in  1  downstream accepts.
- out_result  out  DATA_W  ALU result.
- out_opa  out  DATA_W  operand A passthrough.
- out_rd  out  RD_W  destination register passthrough.
- out_tag  out  TAG_W  side-band passthrough.
- out_wb_en  out  1  result is to be written back.
- out_flags  out  2  full {Z,C} state after this instruction; bit0 is C, bit1 is Z.

## Operation
- **Opcodes:**
  - 00001 ADD: A+B.
  - 00010 ADC: ADD if C.
  - 00011 ADZ: ADD if Z.
  - 00100 ADL: A+(B<<1), dropping bits shifted out above DATA_W.
  - 00101 NDU: ~(A&B).
  - 00110 NDC: NDU if C.
  - 00111 NDZ: NDU if Z.
  - 01000 LHI: {B[8:0], (DATA_W-9) zeros}.
  - 01001 MUL: optional.
  - All others are NOP.
- **Add-family result:** C = carry out of bit DATA_W-1; Z = (result==0).
- **NAND-family result:** Z updated; C unchanged.
- **LHI and NOP:** flags unchanged.
- **Write-back enable:** out_wb_en=1 for executed ALU/LHI/MUL ops, 0 for NOP and suppressed conditionals.
- **Suppressed conditional:** out_result=0, out_wb_en=0, flags passed through unchanged.
- **Effective flags used by a condition:** `eff = out_valid ? out_flags : flag_reg`.
- **Flag commit:** flag_reg ← out_flags on out_valid && out_ready.
- **in_ready** = (state==IDLE) && (!out_valid || out_ready) && !flush.
- **State machine:**
  - IDLE: accepted non-MUL op → output register loads, stay IDLE. Accepted MUL → MUL_BUSY, cycle counter = 0.
  - MUL_BUSY: one shift-add step per cycle. After DATA_W steps, load output register → IDLE.
- **Flush:** priority over all other events.
  - Clears out_valid and returns to IDLE, aborting any MUL.
  - flag_reg is unchanged.
  - No input is accepted in the flush cycle.
- **Output stability:** while out_valid && !out_ready, all out_* hold stable.
- **Reset:**
  - All outputs 0 except in_ready, which is 1 when flush is low.
  - flag_reg = 00; state = IDLE.

## Timing
- Single-cycle ops: accepted at edge N → out_valid at N+1.
- Back-to-back throughput: 1 op/cycle with out_ready held high.
- MUL: accepted at edge N → out_valid at N+DATA_W+1; in_ready is low meanwhile.
- A result is loaded in the same cycle the previous result handshakes.
- Reset asserted mid-MUL: abort immediately, outputs return to their reset values.

## Configuration
- **`EXEC_MUL_EN` defined:**
  - MUL compiled in: iterative unsigned shift-add multiply.
  - out_result = low DATA_W bits of the product.
  - C = OR of the high DATA_W product bits.
  - Z = (low half == 0).
- **`EXEC_MUL_EN` undefined:**
  - Opcode 01001 decodes as NOP.
  - No MUL_BUSY state, multiplier or counter logic exists.
  - in_ready never deasserts for busy.

## Structure
- **Shared package `exec_pkg`:**
  - Opcode localparams: OP_ADD…OP_MUL, OP_NOP.
  - Flag index constants: FLAG_C=0, FLAG_Z=1.
  - State encoding.
- **Sub-module `iter_mul_p`** (parameter DATA_W): start/busy/done, 2·DATA_W product.
  - Instantiated only under `EXEC_MUL_EN`.
  - Has an abort input driven by flush.

## Test plan
- ADD 0xFFFF+0x0001, then ADC 0x0002+0x0003 back-to-back → result 0x0000 with flags C=1, Z=1; next cycle ADC executes: 0x0005, wb_en=1, flags C=0, Z=0 (forwarded flags).
- With C=0: NDC 0x00FF,0x0F0F → wb_en=0, result 0, out_flags equal to the prior value; then LHI imm 0x1FF → 0xFF80 with flags unchanged.
- Hold out_ready=0 for 3 cycles with ADD 0x0001+0x0001 in the output register → out_* stable and in_ready=0; the value 0x0002 is delivered once on release.
- (`EXEC_MUL_EN`) MUL 0x00FF×0x0101 → 0xFFFF, C=0, Z=0, out_valid exactly 17 cycles after acceptance; MUL 0x0100×0x0100 → 0x0000, C=1, Z=1.
- Assert flush on cycle 5 of a MUL, with an ADD also waiting → out_valid stays 0, flag_reg unchanged, next op accepted the cycle after flush.
- Drop resetn mid-stream → all outputs 0 and flag_reg=00 immediately; an ADC issued after reset is suppressed.

Source files
------------

// File: rtl/exec_pkg.sv
// ============================================================================
// Module   : exec_pkg
// Brief    : Opcodes, flag indices and FSM encoding shared by the execute stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package exec_pkg;

  localparam logic [4:0] OP_NOP = 5'b00000;
  localparam logic [4:0] OP_ADD = 5'b00001;
  localparam logic [4:0] OP_ADC = 5'b00010;
  localparam logic [4:0] OP_ADZ = 5'b00011;
  localparam logic [4:0] OP_ADL = 5'b00100;
  localparam logic [4:0] OP_NDU = 5'b00101;
  localparam logic [4:0] OP_NDC = 5'b00110;
  localparam logic [4:0] OP_NDZ = 5'b00111;
  localparam logic [4:0] OP_LHI = 5'b01000;
  localparam logic [4:0] OP_MUL = 5'b01001;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/iter_mul_p.sv
// ============================================================================
// Module   : iter_mul_p
// Brief    : Iterative unsigned shift-add multiplier, one partial product per cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module iter_mul_p #(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  busy,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0]   mcand_q, mcand_d;
  logic [2*DATA_W-1:0] prod_q,  prod_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic                busy_q,  busy_d;
  logic                done_q,  done_d;
  logic [DATA_W:0]     partial;

  // Upper half accumulates the multiplicand; multiplier bits drain out of the low end.
  always_comb begin
    mcand_d = mcand_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    partial = {1'b0, prod_q[2*DATA_W-1:DATA_W]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    if (abort) begin
      busy_d = 1'b0;
      done_d = 1'b0;
    end else if (start) begin
      mcand_d = a;
      prod_d  = {{DATA_W{1'b0}}, b};
      cnt_d   = '0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
    end else if (busy_q) begin
      prod_d = {partial, prod_q[DATA_W-1:1]};
      cnt_d  = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(DATA_W - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = prod_q;

endmodule

`default_nettype wire

// File: rtl/exec_stage_p.sv
// ============================================================================
// Module   : exec_stage_p
// Brief    : Handshaked execute stage (ADD/NAND/LHI, conditional variants).
//            Define EXEC_MUL_EN to add the iterative multiply (opcode 01001).
// Revision : 1.0
// ============================================================================
`default_nettype none

module exec_stage_p
  import exec_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int RD_W   = 3,
  parameter int TAG_W  = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [DATA_W-1:0] in_opa,
  input  logic [DATA_W-1:0] in_opb,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_opa,
  output logic [RD_W-1:0]   out_rd,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_wb_en,
  output logic [1:0]        out_flags
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_result_q, out_result_d;
  logic [DATA_W-1:0] out_opa_q, out_opa_d;
  logic [RD_W-1:0]   out_rd_q, out_rd_d;
  logic [TAG_W-1:0]  out_tag_q, out_tag_d;
  logic              out_wb_en_q, out_wb_en_d;
  logic [1:0]        out_flags_q, out_flags_d;
  logic [1:0]        flag_q, flag_d;

  logic              idle, accept, can_load;
  logic [1:0]        eff_flags, alu_flags;
  logic [DATA_W-1:0] add_b, alu_result;
  logic [DATA_W:0]   add_sum;
  logic              alu_wb_en, cond_ok;

`ifdef EXEC_MUL_EN
  state_e              state_q, state_d;
  logic [DATA_W-1:0]   mul_opa_q, mul_opa_d;
  logic [RD_W-1:0]     mul_rd_q, mul_rd_d;
  logic [TAG_W-1:0]    mul_tag_q, mul_tag_d;
  logic                is_mul, mul_start, mul_busy, mul_done;
  logic [2*DATA_W-1:0] mul_prod;

  assign idle      = (state_q == ST_IDLE);
  assign is_mul    = (in_op == OP_MUL);
  assign mul_start = accept && is_mul;

  iter_mul_p #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .resetn  (resetn),
    .start   (mul_start),
    .abort   (flush),
    .a       (in_opa),
    .b       (in_opb),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );
`else
  assign idle = 1'b1;
`endif

  assign can_load = !out_valid_q || out_ready;
  assign in_ready = idle && can_load && !flush;
  assign accept   = in_valid && in_ready;

  // Conditions read the in-flight result's flags so back-to-back ops see forwarded C/Z.
  always_comb begin
    eff_flags = out_valid_q ? out_flags_q : flag_q;
    add_b     = (in_op == OP_ADL) ? (in_opb << 1) : in_opb;
    add_sum   = {1'b0, in_opa} + {1'b0, add_b};
    cond_ok   = 1'b1;
    if (in_op == OP_ADC || in_op == OP_NDC) cond_ok = eff_flags[FLAG_C];
    if (in_op == OP_ADZ || in_op == OP_NDZ) cond_ok = eff_flags[FLAG_Z];
    alu_result = '0;
    alu_wb_en  = 1'b0;
    alu_flags  = eff_flags;
    case (in_op)
      OP_ADD, OP_ADC, OP_ADZ, OP_ADL: begin
        if (cond_ok) begin
          alu_result        = add_sum[DATA_W-1:0];
          alu_wb_en         = 1'b1;
          alu_flags[FLAG_C] = add_sum[DATA_W];
          alu_flags[FLAG_Z] = (add_sum[DATA_W-1:0] == '0);
        end
      end
      OP_NDU, OP_NDC, OP_NDZ: begin
        if (cond_ok) begin
          alu_result        = ~(in_opa & in_opb);
          alu_wb_en         = 1'b1;
          alu_flags[FLAG_Z] = (alu_result == '0);
        end
      end
      OP_LHI: begin
        alu_result = DATA_W'(in_opb[8:0]) << (DATA_W - 9);
        alu_wb_en  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_opa_d    = out_opa_q;
    out_rd_d     = out_rd_q;
    out_tag_d    = out_tag_q;
    out_wb_en_d  = out_wb_en_q;
    out_flags_d  = out_flags_q;
    flag_d       = flag_q;
`ifdef EXEC_MUL_EN
    state_d   = state_q;
    mul_opa_d = mul_opa_q;
    mul_rd_d  = mul_rd_q;
    mul_tag_d = mul_tag_q;
`endif
    if (flush) begin
      out_valid_d = 1'b0;
`ifdef EXEC_MUL_EN
      state_d = ST_IDLE;
`endif
    end else begin
      if (out_valid_q && out_ready) begin
        flag_d      = out_flags_q;
        out_valid_d = 1'b0;
      end
`ifdef EXEC_MUL_EN
      if (mul_start) begin
        state_d   = ST_MUL_BUSY;
        mul_opa_d = in_opa;
        mul_rd_d  = in_rd;
        mul_tag_d = in_tag;
      end
      // A finished product waits in the multiplier until the output register frees up.
      if (state_q == ST_MUL_BUSY && mul_done && !mul_busy && can_load) begin
        state_d             = ST_IDLE;
        out_valid_d         = 1'b1;
        out_result_d        = mul_prod[DATA_W-1:0];
        out_opa_d           = mul_opa_q;
        out_rd_d            = mul_rd_q;
        out_tag_d           = mul_tag_q;
        out_wb_en_d         = 1'b1;
        out_flags_d[FLAG_C] = |mul_prod[2*DATA_W-1:DATA_W];
        out_flags_d[FLAG_Z] = (mul_prod[DATA_W-1:0] == '0);
      end
      if (accept && !is_mul) begin
`else
      if (accept) begin
`endif
        out_valid_d  = 1'b1;
        out_result_d = alu_result;
        out_opa_d    = in_opa;
        out_rd_d     = in_rd;
        out_tag_d    = in_tag;
        out_wb_en_d  = alu_wb_en;
        out_flags_d  = alu_flags;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_opa_q    <= '0;
      out_rd_q     <= '0;
      out_tag_q    <= '0;
      out_wb_en_q  <= 1'b0;
      out_flags_q  <= '0;
      flag_q       <= '0;
`ifdef EXEC_MUL_EN
      state_q   <= ST_IDLE;
      mul_opa_q <= '0;
      mul_rd_q  <= '0;
      mul_tag_q <= '0;
`endif
    end else begin
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_opa_q    <= out_opa_d;
      out_rd_q     <= out_rd_d;
      out_tag_q    <= out_tag_d;
      out_wb_en_q  <= out_wb_en_d;
      out_flags_q  <= out_flags_d;
      flag_q       <= flag_d;
`ifdef EXEC_MUL_EN
      state_q   <= state_d;
      mul_opa_q <= mul_opa_d;
      mul_rd_q  <= mul_rd_d;
      mul_tag_q <= mul_tag_d;
`endif
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_opa    = out_opa_q;
  assign out_rd     = out_rd_q;
  assign out_tag    = out_tag_q;
  assign out_wb_en  = out_wb_en_q;
  assign out_flags  = out_flags_q;

endmodule

`default_nettype wire
